// File: rtl/stream_serializer.sv
// -----------------------------------------------------------------------------
// stream_serializer
//
// Width-down stream converter on the transmit side. It accepts one wide word
// per input handshake and emits it as up to Ratio narrow beats on a
// valid/ready stream. Each word carries its own beat count, and the final
// beat of each word is flagged with m_last_o. This is the counterpart of the
// receive-side byte-to-word packer.
//
// Parameters:
//   InWidth   width of the input word in bits (default 32)
//   OutWidth  width of each output beat in bits (default 8)
//   Ratio     InWidth/OutWidth, the maximum number of beats per word (derived)
//
// Ports:
//   clock_i    in   1                clock
//   reset_ni   in   1                asynchronous active-low reset
//   s_valid_i  in   1                input word valid
//   s_ready_o  out  1                input word ready (combinational from m_ready_i)
//   s_data_i   in   InWidth          input word
//   s_len_i    in   $clog2(Ratio)    beats to emit minus 1, sampled with the word
//   m_valid_o  out  1                output beat valid
//   m_ready_i  in   1                output beat ready
//   m_data_o   out  OutWidth         output beat
//   m_last_o   out  1                final beat of the current word
//
// Optional feature macro: STREAM_SERIALIZER_MSB_FIRST_EN
//   Defined   : beats leave MSB first (left shift; s_len_i counts from the top).
//   Undefined : beats leave LSB first (right shift). This is the default build.
// -----------------------------------------------------------------------------
module stream_serializer #(
    parameter int InWidth  = 32,
    parameter int OutWidth = 8
) (
    input  logic                                  clock_i,
    input  logic                                  reset_ni,
    input  logic                                  s_valid_i,
    output logic                                  s_ready_o,
    input  logic [InWidth-1:0]                    s_data_i,
    input  logic [$clog2(InWidth/OutWidth)-1:0]   s_len_i,
    output logic                                  m_valid_o,
    input  logic                                  m_ready_i,
    output logic [OutWidth-1:0]                   m_data_o,
    output logic                                  m_last_o
);

    localparam int Ratio    = InWidth / OutWidth;
    localparam int CntWidth = $clog2(Ratio);

    // Refuse to elaborate with a geometry the shift/counter scheme cannot
    // represent: the word must split evenly into a power-of-two beat count.
    if (((InWidth % OutWidth) != 0) || (Ratio < 2) || ((Ratio & (Ratio - 1)) != 0)) begin : g_param_check
        $error("stream_serializer: InWidth must be a power-of-two multiple (>=2) of OutWidth");
    end

    localparam logic [0:0] StateIdle  = 1'b0;
    localparam logic [0:0] StateShift = 1'b1;

    logic [0:0]          state_q;
    logic [InWidth-1:0]  hold_q;
    logic [InWidth-1:0]  hold_shifted;
    logic [CntWidth-1:0] cnt_q;
    logic                accept;
    logic                beat_done;

    assign m_valid_o = (state_q == StateShift);
    assign m_last_o  = m_valid_o && (cnt_q == '0);

    // Ready whenever nothing is held, or when the last beat leaves on this
    // edge, so the next word can be captured without an idle cycle.
    assign s_ready_o = !m_valid_o || (m_ready_i && m_last_o);

    assign accept    = s_valid_i && s_ready_o;
    assign beat_done = m_valid_o && m_ready_i;

    // The current beat always sits at one end of the holding register; each
    // output handshake shifts the next beat into that position.
`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
    assign m_data_o     = hold_q[InWidth-1 -: OutWidth];
    assign hold_shifted = hold_q << OutWidth;
`else
    assign m_data_o     = hold_q[OutWidth-1:0];
    assign hold_shifted = hold_q >> OutWidth;
`endif

    // Word capture has priority: it can only coincide with a handshake on the
    // last beat, in which case the old word is finished anyway. The counter
    // only decrements on non-last beats, so it is non-zero and never wraps.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StateIdle;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            state_q <= StateShift;
            hold_q  <= s_data_i;
            cnt_q   <= s_len_i;
        end else if (beat_done) begin
            if (m_last_o) begin
                state_q <= StateIdle;
                hold_q  <= '0;
            end else begin
                hold_q <= hold_shifted;
                cnt_q  <= cnt_q - CntWidth'(1);
            end
        end
    end

endmodule
